// File: rtl/ser_feeder_if.sv
// ---------------------------------------------------------------------------
// ser_feeder_if
//   Bundles the two data paths of the serializer feeder:
//     - upstream word handshake : i_valid, i_data, o_ready
//     - serializer write port   : o_ser_wen, o_ser_data, i_ser_busy
//   Signal names keep the feeder's point of view (i_* into the feeder,
//   o_* out of it).
//   Modports:
//     slave  - the feeder itself
//     master - the environment around it (upstream source + serializer)
// ---------------------------------------------------------------------------
interface ser_feeder_if #(
  parameter int WIDTH = 8
) ();

  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_ser_wen;
  logic [WIDTH-1:0] o_ser_data;
  logic             i_ser_busy;

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_ser_busy,
    output o_ready,
    output o_ser_wen,
    output o_ser_data
  );

  modport master (
    output i_valid,
    output i_data,
    output i_ser_busy,
    input  o_ready,
    input  o_ser_wen,
    input  o_ser_data
  );

endinterface

// File: rtl/ser_feeder.sv
// ---------------------------------------------------------------------------
// ser_feeder
//   Buffered feeder for the serdes serializer. Parallel words are accepted
//   over a valid/ready handshake into a small circular FIFO and handed to
//   the serializer one at a time as a single-cycle write strobe. A write is
//   only issued while the serializer reports idle, and the feeder then
//   waits for the resulting frame (busy high, then low) before issuing the
//   next one. If busy never rises after a write, the wait is abandoned after
//   BUSY_TIMEOUT cycles and a sticky error flag is raised.
//
// Parameters:
//   WIDTH        - word width (must match the serializer)
//   DEPTH_LOG2   - FIFO holds 2**DEPTH_LOG2 words
//   BUSY_TIMEOUT - cycles to wait for busy to rise after a write (>= 1)
//
// Ports:
//   i_clk     - clock, rising edge
//   i_rst_n   - asynchronous active-low reset
//   bus       - ser_feeder_if.slave: upstream handshake + serializer port
//   o_level   - FIFO occupancy, 0 .. 2**DEPTH_LOG2
//   o_idle    - FSM idle and FIFO empty
//   o_err     - sticky busy-timeout flag, cleared only by reset
//   o_drop_cnt- (only with SER_FEEDER_DROP_CNT_EN) saturating count of
//               cycles where upstream offered a word while the FIFO was full
//
// Optional feature macro: SER_FEEDER_DROP_CNT_EN
// ---------------------------------------------------------------------------
module ser_feeder #(
  parameter int WIDTH        = 8,
  parameter int DEPTH_LOG2   = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ser_feeder_if.slave       bus,
  output logic [DEPTH_LOG2:0] o_level,
  output logic              o_idle,
  output logic              o_err
`ifdef SER_FEEDER_DROP_CNT_EN
  ,
  output logic [15:0]       o_drop_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [DEPTH_LOG2:0] CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_EMPTY = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // State and FIFO storage
  state_e                state_q,   state_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q,  wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q,  rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,   count_d;
  logic [TO_W-1:0]       to_cnt_q,  to_cnt_d;

  // Registered outputs
  logic                  ready_q,   ready_d;
  logic                  wen_q,     wen_d;
  logic [WIDTH-1:0]      data_q,    data_d;
  logic                  idle_q,    idle_d;
  logic                  err_q,     err_d;
`ifdef SER_FEEDER_DROP_CNT_EN
  logic [15:0]           drop_q,    drop_d;
`endif

  logic push_s;
  logic pop_s;

  // Next-state logic for the issue FSM, the FIFO and all registered outputs
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    to_cnt_d = to_cnt_q;
    wen_d    = 1'b0;
    data_d   = data_q;
    err_d    = err_q;
    pop_s    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    // ready is the registered not-full flag, so a pop in the same cycle
    // never lets a full FIFO take a word.
    push_s = bus.i_valid && ready_q;

    case (state_q)
      ST_IDLE: begin
        // Only start a write when the serializer is not mid-frame.
        if ((count_q != CNT_EMPTY) && !bus.i_ser_busy) begin
          state_d = ST_ISSUE;
          wen_d   = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          pop_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d  = ST_WAIT_BUSY;
        to_cnt_d = {TO_W{1'b0}};
      end
      ST_WAIT_BUSY: begin
        if (bus.i_ser_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          // Serializer never acknowledged the write; give up on this word.
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.i_ser_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push_s) begin
      mem_d[wr_ptr_q] = bus.i_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flags are registered from next-state values so they line up with
    // o_level and the FSM state on the same edge.
    ready_d = (count_d != CNT_FULL);
    idle_d  = (state_d == ST_IDLE) && (count_d == CNT_EMPTY);
  end

`ifdef SER_FEEDER_DROP_CNT_EN
  // Saturating count of cycles where a word was offered into a full FIFO
  always_comb begin
    if (bus.i_valid && !ready_q && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
  end
`endif

  // State, FIFO and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q <= {DEPTH_LOG2{1'b0}};
      count_q  <= CNT_EMPTY;
      to_cnt_q <= {TO_W{1'b0}};
      ready_q  <= 1'b1;
      wen_q    <= 1'b0;
      data_q   <= {WIDTH{1'b0}};
      idle_q   <= 1'b1;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
`ifdef SER_FEEDER_DROP_CNT_EN
      drop_q   <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      to_cnt_q <= to_cnt_d;
      ready_q  <= ready_d;
      wen_q    <= wen_d;
      data_q   <= data_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
`ifdef SER_FEEDER_DROP_CNT_EN
      drop_q   <= drop_d;
`endif
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_ser_wen  = wen_q;
  assign bus.o_ser_data = data_q;
  assign o_level        = count_q;
  assign o_idle         = idle_q;
  assign o_err          = err_q;
`ifdef SER_FEEDER_DROP_CNT_EN
  assign o_drop_cnt     = drop_q;
`endif

endmodule

// File: tb/tb_ser_feeder.sv
// ---------------------------------------------------------------------------
// tb_ser_feeder
//   Self-checking bench for ser_feeder. A small serializer model raises
//   busy for FRAME_LEN cycles after each strobe (or never, or always, under
//   bench control). Accepted words are pushed to a scoreboard queue at the
//   handshake edge and popped/compared on every write strobe.
// ---------------------------------------------------------------------------
module tb_ser_feeder;

  localparam int WIDTH        = 8;
  localparam int DEPTH_LOG2   = 2;
  localparam int BUSY_TIMEOUT = 4;
  localparam int FRAME_LEN    = 8;

  logic clk = 1'b0;
  logic rst_n;

  ser_feeder_if #(.WIDTH(WIDTH)) bus ();

  logic [DEPTH_LOG2:0] level;
  logic                idle;
  logic                err;
`ifdef SER_FEEDER_DROP_CNT_EN
  logic [15:0]         drop_cnt;
`endif

  ser_feeder #(
    .WIDTH       (WIDTH),
    .DEPTH_LOG2  (DEPTH_LOG2),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus),
    .o_level(level),
    .o_idle (idle),
    .o_err  (err)
`ifdef SER_FEEDER_DROP_CNT_EN
    ,
    .o_drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serializer model
  logic force_busy = 1'b0;
  logic no_frame   = 1'b0;
  int   frame_cnt  = 0;

  always @(posedge clk) begin
    if (bus.o_ser_wen && !no_frame) frame_cnt <= FRAME_LEN;
    else if (frame_cnt != 0)        frame_cnt <= frame_cnt - 1;
  end

  assign bus.i_ser_busy = force_busy || (frame_cnt != 0);

  // Scoreboard
  logic [WIDTH-1:0] sb_q[$];
  int strobe_cnt = 0;

  always @(posedge clk) begin
    if (rst_n && bus.i_valid && bus.o_ready) sb_q.push_back(bus.i_data);
  end

  always @(negedge clk) begin
    if (rst_n && bus.o_ser_wen) begin
      strobe_cnt++;
      chk("wen_while_busy", 32'(bus.i_ser_busy), 32'd0);
      if (sb_q.size() == 0) chk("unexpected_wen", 32'd1, 32'd0);
      else                  chk("ser_data", 32'(bus.o_ser_data), 32'(sb_q.pop_front()));
    end
  end

`ifdef SER_FEEDER_DROP_CNT_EN
  int stall_cnt = 0;
  always @(posedge clk) begin
    if (rst_n && bus.i_valid && !bus.o_ready) stall_cnt++;
  end
`endif

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_q.delete();
    rst_n = 1'b1;
    cyc(1);
  endtask

  // Offer a word and hold it until accepted; returns 1 time unit after the
  // accepting edge.
  task automatic push(input logic [WIDTH-1:0] d);
    int guard;
    guard       = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    while (!bus.o_ready && guard < 200) begin
      cyc(1);
      guard++;
    end
    if (guard >= 200) chk("push_timeout", 32'd0, 32'd1);
    cyc(1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (!(idle && sb_q.size() == 0 && !bus.i_ser_busy) && g < 400) begin
      cyc(1);
      g++;
    end
    chk(tag, 32'(idle), 32'd1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"}, 32'(bus.o_ready),    32'd1);
    chk({pfx, "_wen"},   32'(bus.o_ser_wen),  32'd0);
    chk({pfx, "_data"},  32'(bus.o_ser_data), 32'd0);
    chk({pfx, "_level"}, 32'(level),          32'd0);
    chk({pfx, "_idle"},  32'(idle),           32'd1);
    chk({pfx, "_err"},   32'(err),            32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int g;

    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    do_reset();
    chk_reset_vals("rst");
`ifdef SER_FEEDER_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt), 32'd0);
`endif

    // T1: single word, latency and hold
    push(8'h18);
    chk("t1_level_n",  32'(level), 32'd1);
    chk("t1_wen_n",    32'(bus.o_ser_wen), 32'd0);
    chk("t1_idle_n",   32'(idle), 32'd0);
    cyc(1);
    chk("t1_wen_n1",   32'(bus.o_ser_wen), 32'd1);
    chk("t1_data_n1",  32'(bus.o_ser_data), 32'h18);
    chk("t1_level_n1", 32'(level), 32'd0);
    cyc(1);
    chk("t1_wen_n2",   32'(bus.o_ser_wen), 32'd0);
    chk("t1_hold_n2",  32'(bus.o_ser_data), 32'h18);
    g = 0;
    while (bus.i_ser_busy && g < 50) begin
      chk("t1_idle_busy", 32'(idle), 32'd0);
      cyc(1);
      g++;
    end
    cyc(1);
    chk("t1_idle_after", 32'(idle), 32'd1);
    chk("t1_strobes", 32'(strobe_cnt), 32'd1);

    // T2: burst fills the FIFO, sixth word stalls
    s0 = strobe_cnt;
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("t2_ready_full", 32'(bus.o_ready), 32'd0);
    chk("t2_level_full", 32'(level), 32'd4);
    push(8'h06);
    drain("t2_drain");
    chk("t2_strobes", 32'(strobe_cnt - s0), 32'd6);
`ifdef SER_FEEDER_DROP_CNT_EN
    chk("t2_drop", 32'(drop_cnt), 32'(stall_cnt));
`endif

    // T3: busy held from reset blocks the strobe
    force_busy = 1'b1;
    do_reset();
    s0 = strobe_cnt;
    push(8'hA5);
    cyc(10);
    chk("t3_no_wen",   32'(strobe_cnt - s0), 32'd0);
    chk("t3_level",    32'(level), 32'd1);
    chk("t3_not_idle", 32'(idle), 32'd0);
    force_busy = 1'b0;
    cyc(1);
    chk("t3_wen",  32'(bus.o_ser_wen), 32'd1);
    chk("t3_data", 32'(bus.o_ser_data), 32'hA5);
    drain("t3_drain");

    // T4: busy never rises -> timeout, sticky error
    no_frame = 1'b1;
    s0 = strobe_cnt;
    push(8'h3C);
    cyc(1);
    chk("t4_wen", 32'(bus.o_ser_wen), 32'd1);
    cyc(4);
    chk("t4_err_early", 32'(err), 32'd0);
    cyc(1);
    chk("t4_err",  32'(err), 32'd1);
    chk("t4_idle", 32'(idle), 32'd1);
    push(8'h3D);
    drain("t4_drain");
    chk("t4_err_sticky", 32'(err), 32'd1);
    chk("t4_strobes", 32'(strobe_cnt - s0), 32'd2);
    no_frame = 1'b0;

    // T5: reset mid-frame with three words queued
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h51 + 8'(i));
    chk("t5_level_q", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t5");
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s0 = strobe_cnt;
    cyc(15);
    chk("t5_no_wen",   32'(strobe_cnt - s0), 32'd0);
    chk("t5_level_0",  32'(level), 32'd0);
    g = 0;
    while (bus.i_ser_busy && g < 50) begin
      cyc(1);
      g++;
    end

    // T6: simultaneous push/pop at level 2, then pointer wrap
    s0 = strobe_cnt;
    force_busy = 1'b1;
    push(8'h60);
    push(8'h61);
    chk("t6_level2", 32'(level), 32'd2);
    force_busy  = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h62;
    cyc(1);
    bus.i_valid = 1'b0;
    chk("t6_pushpop_level", 32'(level), 32'd2);
    chk("t6_pushpop_wen",   32'(bus.o_ser_wen), 32'd1);
    for (int i = 0; i < 8; i++) push(8'h63 + 8'(i));
    drain("t6_drain");
    chk("t6_strobes", 32'(strobe_cnt - s0), 32'd11);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
